// File: rtl/pulse_counter_pkg.sv
// Shared widths and helpers for the pulse-width-qualified event counter.
package pulse_counter_pkg;

  localparam int DEF_PULSE_LEN = 2;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_NUM_CH    = 1;

  function automatic int run_width(input int pulse_len);
    return (pulse_len <= 2) ? 1 : $clog2(pulse_len);
  endfunction

  // LSB of channel ch inside the packed cnt bus.
  function automatic int cnt_lsb(input int ch, input int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/pulse_run_counter.sv
// Single channel: qualifies runs of PULSE_LEN high cycles and counts them.
// CNT_SAT_EN selects a saturating event counter; otherwise it wraps.
module pulse_run_counter
  import pulse_counter_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             evt,
  output logic             ovf
);

  localparam int RUN_W = run_width(PULSE_LEN);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PULSE_LEN - 1);

  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic             run_done;
  logic             cnt_max;

  always_comb begin
    run_done = inc && (run == RUN_LAST);
    cnt_max  = (cnt == {CNT_W{1'b1}});
    run_nxt  = '0;
    if (inc && !run_done) begin
      run_nxt = run + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      run <= '0;
      cnt <= '0;
      evt <= 1'b0;
      ovf <= 1'b0;
    end else begin
      run <= run_nxt;
      evt <= run_done;
      if (run_done) begin
        if (cnt_max) begin
          ovf <= 1'b1;
`ifdef CNT_SAT_EN
          cnt <= cnt;
`else
          cnt <= '0;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_pulse_counter.sv
// NUM_CH independent pulse-qualified event counters with packed outputs.
// Counter overflow behaviour follows CNT_SAT_EN (see pulse_run_counter).
module multi_pulse_counter
  import pulse_counter_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int NUM_CH    = DEF_NUM_CH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic [NUM_CH-1:0]       evt,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pulse_run_counter #(
      .PULSE_LEN (PULSE_LEN),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .inc (inc[k]),
      .clr (clr[k]),
      .cnt (cnt[cnt_lsb(k, CNT_W) +: CNT_W]),
      .evt (evt[k]),
      .ovf (ovf[k])
    );
  end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Self-checking bench: directed scenarios plus random traffic against a run-length model.
module tb_multi_pulse_counter;
  import pulse_counter_pkg::*;

  localparam int PL = 3;
  localparam int CW = 4;
  localparam int NC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC-1:0]  inc, clr;
  logic [NC*CW-1:0] cnt;
  logic [NC-1:0]  evt, ovf;
  logic [0:0]     inc1, clr1, evt1, ovf1;
  logic [CW-1:0]  cnt1;

  int checks = 0;
  int errors = 0;

  // model state: channels 0,1 belong to dut (PL=3), channel 2 to dut1 (PL=1)
  int streak [3];
  int total  [3];
  bit m_evt  [3];
  int plen   [3] = '{PL, PL, 1};

  always #5 clk = ~clk;

  multi_pulse_counter #(.PULSE_LEN(PL), .CNT_W(CW), .NUM_CH(NC)) dut (
    .clk (clk), .rst (rst), .inc (inc), .clr (clr),
    .cnt (cnt), .evt (evt), .ovf (ovf)
  );

  multi_pulse_counter #(.PULSE_LEN(1), .CNT_W(CW), .NUM_CH(1)) dut1 (
    .clk (clk), .rst (rst), .inc (inc1), .clr (clr1),
    .cnt (cnt1), .evt (evt1), .ovf (ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int t);
`ifdef CNT_SAT_EN
    return (t > (1 << CW) - 1) ? (1 << CW) - 1 : t;
`else
    return t % (1 << CW);
`endif
  endfunction

  task automatic model_edge();
    logic [2:0] i_v;
    logic [2:0] c_v;
    i_v = {inc1, inc};
    c_v = {clr1, clr};
    for (int ch = 0; ch < 3; ch++) begin
      if (rst || c_v[ch]) begin
        streak[ch] = 0;
        total[ch]  = 0;
        m_evt[ch]  = 1'b0;
      end else begin
        m_evt[ch] = 1'b0;
        if (i_v[ch]) begin
          streak[ch]++;
          if (streak[ch] % plen[ch] == 0) begin
            total[ch]++;
            m_evt[ch] = 1'b1;
          end
        end else begin
          streak[ch] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int ch = 0; ch < NC; ch++) begin
      chk($sformatf("cnt%0d", ch), 32'(cnt[cnt_lsb(ch, CW) +: CW]), 32'(exp_cnt(total[ch])));
      chk($sformatf("evt%0d", ch), 32'(evt[ch]), 32'(m_evt[ch]));
      chk($sformatf("ovf%0d", ch), 32'(ovf[ch]), 32'(total[ch] >= (1 << CW)));
    end
    chk("pl1_cnt", 32'(cnt1), 32'(exp_cnt(total[2])));
    chk("pl1_evt", 32'(evt1), 32'(m_evt[2]));
    chk("pl1_ovf", 32'(ovf1), 32'(total[2] >= (1 << CW)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int pulses;
  int last_evt;

  initial begin
    for (int ch = 0; ch < 3; ch++) begin
      streak[ch] = 0;
      total[ch]  = 0;
      m_evt[ch]  = 1'b0;
    end

    // reset with inc held high
    rst = 1'b1; inc = 2'b11; clr = 2'b00; inc1 = 1'b1; clr1 = 1'b0;
    step();
    chk("rst_cnt", 32'(cnt), 32'd0);
    step();
    chk("rst_ovf", 32'({ovf, evt}), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_cnt", 32'(cnt), 32'd0);
    chk("post_rst_evt", 32'(evt), 32'd0);
    inc = 2'b00; inc1 = 1'b0;
    clr = 2'b11; clr1 = 1'b1;
    step();
    clr = 2'b00; clr1 = 1'b0;

    // run qualification: 7 highs on ch0
    pulses = 0; last_evt = -10;
    inc = 2'b01;
    for (int i = 0; i < 7; i++) begin
      step();
      if (evt[0]) begin
        if (pulses == 1) chk("rq_spacing", 32'(i - last_evt), 32'd3);
        pulses++;
        last_evt = i;
      end
    end
    inc = 2'b00;
    step();
    chk("rq_pulses", 32'(pulses), 32'd2);
    chk("rq_cnt0", 32'(cnt[3:0]), 32'd2);
    chk("rq_cnt1", 32'(cnt[7:4]), 32'd0);

    // broken run 1,1,0,1,1,1
    clr = 2'b01;
    step();
    clr = 2'b00;
    foreach (plen[i]) begin end
    begin
      logic [5:0] pat;
      pat = 6'b111011;
      for (int i = 0; i < 6; i++) begin
        inc = {1'b0, pat[i]};
        step();
      end
    end
    chk("br_cnt", 32'(cnt[3:0]), 32'd1);
    inc = 2'b00;
    step();

    // overflow ch1 through 16 events
    inc = 2'b10;
    for (int i = 0; i < 16 * PL; i++) step();
`ifdef CNT_SAT_EN
    chk("ovf_cnt", 32'(cnt[7:4]), 32'd15);
`else
    chk("ovf_cnt", 32'(cnt[7:4]), 32'd0);
`endif
    chk("ovf_flag", 32'(ovf[1]), 32'd1);
    chk("ovf_evt", 32'(evt[1]), 32'd1);
    inc = 2'b00;
    step();

    // clear collides with completing run on ch0
    clr = 2'b01;
    step();
    clr = 2'b00;
    inc = 2'b01;
    step();
    step();
    clr = 2'b01;
    step();
    clr = 2'b00;
    inc = 2'b00;
    chk("col_cnt", 32'(cnt[3:0]), 32'd0);
    chk("col_evt", 32'(evt[0]), 32'd0);
    chk("col_ovf", 32'(ovf[0]), 32'd0);
    chk("col_ch1_ovf", 32'(ovf[1]), 32'd1);
    step();

    // PULSE_LEN=1 channel: 5 highs
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    inc1 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) chk("pl1_latency", 32'(evt1), 32'd1);
      if (evt1) pulses++;
    end
    inc1 = 1'b0;
    chk("pl1_pulses", 32'(pulses), 32'd5);
    chk("pl1_cnt5", 32'(cnt1), 32'd5);
    step();
    chk("pl1_evt_drop", 32'(evt1), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      inc  = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
      inc1 = ($urandom_range(0, 2) != 0);
      clr  = {($urandom_range(0, 60) == 0), ($urandom_range(0, 60) == 0)};
      clr1 = ($urandom_range(0, 80) == 0);
      rst  = ($urandom_range(0, 250) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pulse_counter.md
# multi_pulse_counter

Multi-channel pulse-width-qualified event counter. Each channel counts one event per complete run of `PULSE_LEN` consecutive cycles with its `inc` input high. Counter width, run length and channel count are parameters. Each channel adds a synchronous clear, a one-cycle event strobe and a sticky overflow flag. It sits between debounced or qualified strobes and the status/CSR logic that reads event totals.

## Interface
- `PULSE_LEN`, default 2: consecutive high cycles of `inc` per counted event; legal range ≥1.
- `CNT_W`, default 4: width of each channel's event counter.
- `NUM_CH`, default 1: number of independent channels.
- `clk` input, 1 bit: single clock; all logic on rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `inc` input, `NUM_CH` bits: per-channel increment request, sampled every cycle.
- `clr` input, `NUM_CH` bits: per-channel synchronous clear of count, run state and overflow.
- `cnt` output, `NUM_CH*CNT_W` bits: channel k occupies bits `[k*CNT_W +: CNT_W]`; registered.
- `evt` output, `NUM_CH` bits: registered one-cycle strobe, high in the cycle `cnt` shows a new increment.
- `ovf` output, `NUM_CH` bits: sticky overflow flag, registered.

## Operation
- Per channel, the run counter `run` is `RUN_W = max(1, clog2(PULSE_LEN))` bits wide and holds values 0..`PULSE_LEN`-1.
- `inc`=0: `run` returns to 0.
- `inc`=1 and `run` < `PULSE_LEN`-1: `run` increments.
- `inc`=1 and `run` = `PULSE_LEN`-1: `run` returns to 0, an event is counted and `evt` is asserted next cycle.
- A continuous high of k cycles yields floor(k/`PULSE_LEN`) events. A partial run is discarded when `inc` drops.
- `PULSE_LEN`=1: every high cycle of `inc` is an event; `run` stays at 0.
- Counting an event at `cnt` = 2^`CNT_W`-1 sets `ovf`. The value of `cnt` after overflow depends on the configuration macro.
- `ovf` stays set until `clr` or `rst`.
- `clr[k]`=1: channel k's `cnt`, `run`, `evt` and `ovf` go to 0 next cycle. `clr` overrides a simultaneous event; that event is lost.
- Channels are fully independent; there is no cross-channel interaction.

## Timing
- Reset values: `cnt`=0, `evt`=0, `ovf`=0 and `run`=0 on all channels. Reset takes effect at the first rising edge with `rst`=1.
- `rst` mid-run discards partial runs. Counting restarts from `run`=0 on the first cycle after `rst` is deasserted.
- Latency: `inc` high in cycles t-`PULSE_LEN`+1..t gives `cnt`+1 and `evt`=1 in cycle t+1.
- With `inc` held high, `evt` pulses every `PULSE_LEN` cycles. `evt` is never high in two consecutive cycles unless `PULSE_LEN`=1.
- An `inc` low for a single cycle resets the run. The first event after it needs `PULSE_LEN` more high cycles.
- `ovf` is set in the same cycle as the overflowing `evt`.
- `cnt`, `evt` and `ovf` are all flop outputs; there is no combinational path from inputs to outputs.

## Configuration
- `CNT_SAT_EN` defined: saturating counter.
  - At `cnt` = 2^`CNT_W`-1, a further event holds `cnt` at its maximum, still pulses `evt` and sets `ovf`.
- `CNT_SAT_EN` undefined: wrapping counter.
  - The event at `cnt` = 2^`CNT_W`-1 wraps `cnt` to 0, pulses `evt` and sets `ovf`.

## Structure
- Shared package `pulse_counter_pkg`:
  - function `run_width(PULSE_LEN)` returning `max(1, clog2)`;
  - a localparam for the default widths;
  - the `cnt` slice-index helper used by the top level and the bench.
- Sub-module `pulse_run_counter`: single channel containing the run counter, event counter, `evt` and `ovf`.
- Top level: generate loop instancing `pulse_run_counter` `NUM_CH` times and packing the outputs.

## Test plan
All scenarios use `PULSE_LEN`=3, `CNT_W`=4, `NUM_CH`=2 unless stated.
- Reset: hold `rst` 2 cycles with `inc`=2'b11 → `cnt`=0, `evt`=0, `ovf`=0 on both channels during reset and in the first cycle after.
- Run qualification: ch0 `inc` high 7 cycles then low → 2 `evt` pulses, 3 cycles apart; ch0 `cnt`=2; ch1 `cnt` stays 0.
- Broken run: ch0 `inc` pattern 1,1,0,1,1,1 → exactly 1 event, `cnt`=1 the cycle after the 6th sample.
- Overflow: drive ch1 through 16 events.
  - `CNT_SAT_EN` defined → `cnt`=15, `ovf`=1.
  - `CNT_SAT_EN` undefined → `cnt`=0, `ovf`=1.
  - In both builds, `evt` pulses on the 16th event.
- Clear collision: assert `clr[0]` in the cycle ch0 completes a run → `cnt`=0, `evt`=0, `ovf`=0 next cycle; ch1 unaffected.
- `PULSE_LEN`=1, `NUM_CH`=1: `inc` high 5 cycles → `cnt`=5, `evt` high 5 consecutive cycles, 1-cycle latency.
